// File: rtl/data_path_pipelined_pkg.sv
// Shared types for the pipelined data path: ALU opcodes, writeback source select, operand-B select.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package data_path_package;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_AND    = 3'b010,
    ALU_OR     = 3'b011,
    ALU_XOR    = 3'b100,
    ALU_SHL    = 3'b101,
    ALU_SHR    = 3'b110,
    ALU_PASS_B = 3'b111
  } alu_opcode_t;

  typedef enum logic [1:0] {
    SRC_ALU       = 2'd0,
    SRC_IMM1      = 2'd1,
    SRC_OPERAND_A = 2'd2,
    SRC_IMM2      = 2'd3
  } output_source_t;

  localparam logic OPERAND_B_REGISTER  = 1'b0;
  localparam logic OPERAND_B_IMMEDIATE = 1'b1;

endpackage

// File: rtl/data_path_pipelined_alu.sv
// Eight-operation ALU (add, sub, and, or, xor, shl, shr, pass B) with carry/borrow out.
// Latency: purely combinational.
// Backpressure: none.
module data_path_alu
  import data_path_package::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  alu_opcode_t           opcode,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH:0] sum_ext;
  logic [DATA_WIDTH:0] diff_ext;
  logic [SHAMT_W-1:0]  shamt;

  // Operation select; the extended difference's top bit is the unsigned borrow (A < B).
  always_comb begin
    sum_ext  = {1'b0, operand_a} + {1'b0, operand_b};
    diff_ext = {1'b0, operand_a} - {1'b0, operand_b};
    shamt    = operand_b[SHAMT_W-1:0];
    result   = '0;
    carry    = 1'b0;
    case (opcode)
      ALU_ADD: begin
        result = sum_ext[DATA_WIDTH-1:0];
        carry  = sum_ext[DATA_WIDTH];
      end
      ALU_SUB: begin
        result = diff_ext[DATA_WIDTH-1:0];
        carry  = diff_ext[DATA_WIDTH];
      end
      ALU_AND:    result = operand_a & operand_b;
      ALU_OR:     result = operand_a | operand_b;
      ALU_XOR:    result = operand_a ^ operand_b;
      ALU_SHL:    result = operand_a << shamt;
      ALU_SHR:    result = operand_a >> shamt;
      ALU_PASS_B: result = operand_b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/data_path_pipelined.sv
// Two-stage data path: register file read + operand latch, then ALU/writeback with flags. Macro: DATA_PATH_BYPASS_EN.
// Latency: command at edge N, operands visible after N, result_valid and register write after N+1.
// Backpressure: none; one command per cycle, never stalls. Without bypass a dependent next command reads stale data.
module data_path_pipelined
  import data_path_package::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int REGISTER_COUNT = 4,
  localparam int SELECTOR_WIDTH = $clog2(REGISTER_COUNT)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      command_valid,
  input  logic [SELECTOR_WIDTH-1:0] input_register_selector_1,
  input  logic [SELECTOR_WIDTH-1:0] input_register_selector_2,
  input  logic                      operand_b_selector,
  input  logic [SELECTOR_WIDTH-1:0] output_register_selector,
  input  logic [1:0]                output_source_selector,
  input  logic                      output_enable,
  input  logic [2:0]                alu_opcode,
  input  logic [DATA_WIDTH-1:0]     immediate_1,
  input  logic [DATA_WIDTH-1:0]     immediate_2,
  output logic [DATA_WIDTH-1:0]     input_data_1,
  output logic [DATA_WIDTH-1:0]     input_data_2,
  output logic                      result_valid,
  output logic [DATA_WIDTH-1:0]     result_data,
  output logic                      result_zero,
  output logic                      result_carry
);

  // Register file
  logic [DATA_WIDTH-1:0] regs_q [REGISTER_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REGISTER_COUNT];

  // Stage 1 (latched command)
  logic                      s1_valid_q,  s1_valid_d;
  logic [DATA_WIDTH-1:0]     s1_op_a_q,   s1_op_a_d;
  logic [DATA_WIDTH-1:0]     s1_op_b_q,   s1_op_b_d;
  logic [DATA_WIDTH-1:0]     s1_imm1_q,   s1_imm1_d;
  logic [DATA_WIDTH-1:0]     s1_imm2_q,   s1_imm2_d;
  alu_opcode_t               s1_opcode_q, s1_opcode_d;
  output_source_t            s1_source_q, s1_source_d;
  logic [SELECTOR_WIDTH-1:0] s1_dest_q,   s1_dest_d;
  logic                      s1_oe_q,     s1_oe_d;

  // Result registers
  logic                  result_valid_q, result_valid_d;
  logic [DATA_WIDTH-1:0] result_data_q,  result_data_d;
  logic                  result_zero_q,  result_zero_d;
  logic                  result_carry_q, result_carry_d;

  // Combinational intermediates
  logic [DATA_WIDTH-1:0] read_a, read_b, op_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_carry;

  data_path_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .operand_a (s1_op_a_q),
    .operand_b (s1_op_b_q),
    .opcode    (s1_opcode_q),
    .result    (alu_result),
    .carry     (alu_carry)
  );

  // Writeback source mux; carry is only meaningful for ALU results.
  always_comb begin
    wb_data  = alu_result;
    wb_carry = 1'b0;
    case (s1_source_q)
      SRC_ALU: begin
        wb_data  = alu_result;
        wb_carry = alu_carry;
      end
      SRC_IMM1:      wb_data = s1_imm1_q;
      SRC_OPERAND_A: wb_data = s1_op_a_q;
      SRC_IMM2:      wb_data = s1_imm2_q;
      default:       wb_data = alu_result;
    endcase
  end

  // Stage-0 register read, optional forwarding of the in-flight stage-1 result, operand-B select.
  always_comb begin
    read_a = regs_q[input_register_selector_1];
    read_b = regs_q[input_register_selector_2];
`ifdef DATA_PATH_BYPASS_EN
    if (s1_valid_q && s1_oe_q && (s1_dest_q == input_register_selector_1)) read_a = wb_data;
    if (s1_valid_q && s1_oe_q && (s1_dest_q == input_register_selector_2)) read_b = wb_data;
`endif
    op_b = (operand_b_selector == OPERAND_B_IMMEDIATE) ? immediate_2 : read_b;
  end

  // Next-state for stage-1 latch, result registers and register-file writeback.
  always_comb begin
    s1_valid_d  = command_valid;
    s1_op_a_d   = s1_op_a_q;
    s1_op_b_d   = s1_op_b_q;
    s1_imm1_d   = s1_imm1_q;
    s1_imm2_d   = s1_imm2_q;
    s1_opcode_d = s1_opcode_q;
    s1_source_d = s1_source_q;
    s1_dest_d   = s1_dest_q;
    s1_oe_d     = s1_oe_q;
    if (command_valid) begin
      s1_op_a_d   = read_a;
      s1_op_b_d   = op_b;
      s1_imm1_d   = immediate_1;
      s1_imm2_d   = immediate_2;
      s1_opcode_d = alu_opcode_t'(alu_opcode);
      s1_source_d = output_source_t'(output_source_selector);
      s1_dest_d   = output_register_selector;
      s1_oe_d     = output_enable;
    end

    result_valid_d = s1_valid_q;
    result_data_d  = result_data_q;
    result_zero_d  = result_zero_q;
    result_carry_d = result_carry_q;
    regs_d         = regs_q;
    if (s1_valid_q) begin
      result_data_d  = wb_data;
      result_zero_d  = (wb_data == '0);
      result_carry_d = wb_carry;
      if (s1_oe_q) regs_d[s1_dest_q] = wb_data;
    end
  end

  // State registers; reset discards any in-flight command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs_q         <= '{default: '0};
      s1_valid_q     <= 1'b0;
      s1_op_a_q      <= '0;
      s1_op_b_q      <= '0;
      s1_imm1_q      <= '0;
      s1_imm2_q      <= '0;
      s1_opcode_q    <= ALU_ADD;
      s1_source_q    <= SRC_ALU;
      s1_dest_q      <= '0;
      s1_oe_q        <= 1'b0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      result_zero_q  <= 1'b0;
      result_carry_q <= 1'b0;
    end else begin
      regs_q         <= regs_d;
      s1_valid_q     <= s1_valid_d;
      s1_op_a_q      <= s1_op_a_d;
      s1_op_b_q      <= s1_op_b_d;
      s1_imm1_q      <= s1_imm1_d;
      s1_imm2_q      <= s1_imm2_d;
      s1_opcode_q    <= s1_opcode_d;
      s1_source_q    <= s1_source_d;
      s1_dest_q      <= s1_dest_d;
      s1_oe_q        <= s1_oe_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      result_zero_q  <= result_zero_d;
      result_carry_q <= result_carry_d;
    end
  end

  assign input_data_1 = s1_op_a_q;
  assign input_data_2 = s1_op_b_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign result_zero  = result_zero_q;
  assign result_carry = result_carry_q;

endmodule
